// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sequencer
// Brief    : Pipeline-control FSM for the 5-stage RV32I core: load-use
//            interlock, taken-branch squash, dmem wait and memory watchdog.
// Revision : 1.0
// ============================================================================
module hazard_sequencer #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_id_ir,
  input  logic [31:0] id_ex_ir,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    ERROR      = 2'd3
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [1:0] c_bubble_init = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [8:0] c_timeout     = 9'(MEM_TIMEOUT);

  state_t      r_state, w_state_nxt;
  state_t      r_return_state, w_return_nxt;
  logic [1:0]  r_bubble_cnt, w_bubble_nxt;
  logic [7:0]  r_wait_cnt, w_wait_nxt;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  logic        r_mem_timeout;
  logic        w_flush_inc;

  // Load-use detection
  logic [6:0] w_ex_op, w_id_op;
  logic [4:0] w_ex_rd, w_id_rs1, w_id_rs2;
  logic       w_uses_rs1, w_uses_rs2, w_hz, w_mw;
  logic       w_unused_ex;

  assign w_ex_op     = id_ex_ir[6:0];
  assign w_ex_rd     = id_ex_ir[11:7];
  assign w_id_op     = if_id_ir[6:0];
  assign w_id_rs1    = if_id_ir[19:15];
  assign w_id_rs2    = if_id_ir[24:20];
  assign w_unused_ex = ^id_ex_ir[31:12];

  assign w_uses_rs1 = !((w_id_op == c_op_lui) || (w_id_op == c_op_auipc) ||
                        (w_id_op == c_op_jal));
  assign w_uses_rs2 = (w_id_op == c_op_reg) || (w_id_op == c_op_store) ||
                      (w_id_op == c_op_branch);

  assign w_hz = (w_ex_op == c_op_load) && (w_ex_rd != 5'd0) && (if_id_ir != 32'h0) &&
                ((w_uses_rs1 && (w_id_rs1 == w_ex_rd)) ||
                 (w_uses_rs2 && (w_id_rs2 == w_ex_rd)));

  assign w_mw = dmem_req && !dmem_ready;

  // Consecutive mw cycles including the current one: entry cycle + MEM_WAIT cycles so far + this one
  logic [8:0] w_mw_total;
  assign w_mw_total = {1'b0, r_wait_cnt} + 9'd2;

  always_comb begin
    w_state_nxt  = r_state;
    w_return_nxt = r_return_state;
    w_bubble_nxt = r_bubble_cnt;
    w_wait_nxt   = r_wait_cnt;
    w_flush_inc  = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mw) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          w_state_nxt  = MEM_WAIT;
          w_return_nxt = RUN;
          w_wait_nxt   = 8'd0;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_hz) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_bubble_nxt = c_bubble_init;
            w_state_nxt  = LOAD_STALL;
          end
        end
      end
      LOAD_STALL: begin
        if (w_mw) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          w_state_nxt  = MEM_WAIT;
          w_return_nxt = LOAD_STALL;
          w_wait_nxt   = 8'd0;
        end else begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (r_bubble_cnt <= 2'd1) w_state_nxt = RUN;
          else                      w_bubble_nxt = r_bubble_cnt - 2'd1;
        end
      end
      MEM_WAIT: begin
        if (w_mw) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          if (w_mw_total >= c_timeout) w_state_nxt = ERROR;
          else                         w_wait_nxt  = r_wait_cnt + 8'd1;
        end else begin
          w_state_nxt = r_return_state;
        end
      end
      ERROR: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      end
      default: w_state_nxt = RUN;
    endcase

    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_return_state <= RUN;
      r_bubble_cnt   <= 2'd0;
      r_wait_cnt     <= 8'd0;
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 16'd0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_return_state <= w_return_nxt;
      r_bubble_cnt   <= w_bubble_nxt;
      r_wait_cnt     <= w_wait_nxt;
      if (!pc_en && (r_state != ERROR)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_inc)                  r_flush_count  <= r_flush_count + 16'd1;
      if (w_state_nxt == ERROR)         r_mem_timeout  <= 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign mem_timeout  = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sequencer
// Brief    : Directed scoreboard bench; dut_a (1 bubble, timeout 255) and
//            dut_b (3 bubbles, timeout 4) share one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_ir, id_ex_ir;
  logic        ex_branch_taken, dmem_req, dmem_ready;

  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush;
  logic [31:0] a_stall;
  logic [15:0] a_flush;
  logic        a_tmo;
  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush;
  logic [31:0] b_stall;
  logic [15:0] b_flush;
  logic        b_tmo;

  always #5 clk = ~clk;

  hazard_sequencer #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en), .ex_mem_en(a_ex_mem_en),
    .mem_wb_en(a_mem_wb_en), .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .stall_cycles(a_stall), .flush_count(a_flush), .mem_timeout(a_tmo)
  );

  hazard_sequencer #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en), .ex_mem_en(b_ex_mem_en),
    .mem_wb_en(b_mem_wb_en), .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .stall_cycles(b_stall), .flush_count(b_flush), .mem_timeout(b_tmo)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush}
  localparam logic [6:0] c_run    = 7'b11111_00;
  localparam logic [6:0] c_freeze = 7'b00000_00;
  localparam logic [6:0] c_hz     = 7'b00111_01;
  localparam logic [6:0] c_branch = 7'b11111_11;
  localparam logic [6:0] c_reset  = 7'b00000_11;

  localparam logic [31:0] c_lw5  = 32'h0000A283;
  localparam logic [31:0] c_lw0  = 32'h00002003;
  localparam logic [31:0] c_add  = 32'h00728333;
  localparam logic [31:0] c_add0 = 32'h00000333;
  localparam logic [31:0] c_lui5 = 32'h000052B7;
  localparam logic [31:0] c_sw5  = 32'h00512023;
  localparam logic [31:0] c_addi = 32'h00508313;

  typedef struct {
    string       tag;
    bit          sel;
    logic [6:0]  ctl;
    logic [31:0] stall;
    logic [15:0] flush;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic drive(input logic rn, input logic [31:0] ex, input logic [31:0] ifd,
                       input logic br, input logic rq, input logic rdy);
    rst_n = rn; id_ex_ir = ex; if_id_ir = ifd;
    ex_branch_taken = br; dmem_req = rq; dmem_ready = rdy;
  endtask

  task automatic want(input string tag, input bit sel, input logic [6:0] ctl,
                      input logic [31:0] st, input logic [15:0] fl, input logic tmo);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ctl = ctl; e.stall = st; e.flush = fl; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t        e;
    logic [55:0] obs, req;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      req = {e.ctl, e.stall, e.flush, e.tmo};
      if (e.sel)
        obs = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush,
               b_id_ex_flush, b_stall, b_flush, b_tmo};
      else
        obs = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush,
               a_id_ex_flush, a_stall, a_flush, a_tmo};
      vectors++;
      assert (obs === req) else begin
        miscompares++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, req);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(1'b0, c_lw5, c_add, 1'b1, 1'b1, 1'b0);
    want("reset_a", 0, c_reset, 32'd0, 16'd0, 1'b0);
    want("reset_b", 1, c_reset, 32'd0, 16'd0, 1'b0);
    check_cycle();

    // Load-use and non-hazard patterns on dut_a
    drive(1'b1, 32'h0, 32'h0, 0, 0, 0);  want("idle",         0, c_run, 32'd0, 16'd0, 0); check_cycle();
    drive(1'b1, c_lw5, c_add, 0, 0, 0);  want("hz_rs1",       0, c_hz,  32'd0, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 0, 0);  want("after_hz",     0, c_run, 32'd1, 16'd0, 0); check_cycle();
    drive(1'b1, c_lw5, c_sw5, 0, 0, 0);  want("hz_rs2_store", 0, c_hz,  32'd1, 16'd0, 0); check_cycle();
    drive(1'b1, c_lw5, c_addi, 0, 0, 0); want("itype_no_rs2", 0, c_run, 32'd2, 16'd0, 0); check_cycle();
    drive(1'b1, c_lw0, c_add0, 0, 0, 0); want("lw_x0",        0, c_run, 32'd2, 16'd0, 0); check_cycle();
    drive(1'b1, c_lw5, c_lui5, 0, 0, 0); want("lui_consumer", 0, c_run, 32'd2, 16'd0, 0); check_cycle();
    drive(1'b1, c_lw5, 32'h0, 0, 0, 0);  want("if_id_nop",    0, c_run, 32'd2, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 0, 0);  want("id_ex_nop",    0, c_run, 32'd2, 16'd0, 0); check_cycle();

    // Branch beats a simultaneous hazard
    drive(1'b1, c_lw5, c_add, 1, 0, 0);  want("branch_hz",    0, c_branch, 32'd2, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 0, 0);  want("after_branch", 0, c_run,    32'd2, 16'd1, 0); check_cycle();

    // Three-cycle memory wait
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("mw_1",    0, c_freeze, 32'd2, 16'd1, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("mw_2",    0, c_freeze, 32'd3, 16'd1, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("mw_3",    0, c_freeze, 32'd4, 16'd1, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 1);  want("mw_ready",0, c_run,    32'd5, 16'd1, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 0, 0);  want("mw_done", 0, c_run,    32'd5, 16'd1, 0); check_cycle();

    // Memory wait beats branch and hazard
    drive(1'b1, c_lw5, c_add, 1, 1, 0);  want("mw_prio",  0, c_freeze, 32'd5, 16'd1, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 1);  want("mw_prio_r",0, c_run,    32'd6, 16'd1, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 0, 0);  want("idle_2",   0, c_run,    32'd6, 16'd1, 0); check_cycle();

    // Reset both, then bubble resume on dut_b
    drive(1'b0, 32'h0, 32'h0, 0, 0, 0);  want("reset_a2", 0, c_reset, 32'd6, 16'd1, 0); check_cycle();
    drive(1'b1, c_lw5, c_add, 0, 0, 0);  want("b_hz",     1, c_hz,     32'd0, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 1, 0);  want("b_mw_bub2",1, c_freeze, 32'd1, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 1, 0);  want("b_mw_wait",1, c_freeze, 32'd2, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 1, 1);  want("b_mw_rdy", 1, c_run,    32'd3, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 1, 0, 0);  want("b_bub_br", 1, c_hz,     32'd3, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 0, 0);  want("b_bub_3",  1, c_hz,     32'd4, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 0, 0);  want("b_resume", 1, c_run,    32'd5, 16'd0, 0); check_cycle();

    // Watchdog on dut_b (timeout 4)
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("wd_1",     1, c_freeze, 32'd5, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("wd_2",     1, c_freeze, 32'd6, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("wd_3",     1, c_freeze, 32'd7, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("wd_4",     1, c_freeze, 32'd8, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 1, 0);  want("wd_err",   1, c_freeze, 32'd9, 16'd0, 1); check_cycle();
    drive(1'b1, c_lw5, c_add, 1, 1, 1);  want("wd_sticky",1, c_freeze, 32'd9, 16'd0, 1); check_cycle();
    drive(1'b0, 32'h0, 32'h0, 0, 0, 0);  want("wd_rst",   1, c_reset,  32'd9, 16'd0, 1); check_cycle();
    drive(1'b1, 32'h0, 32'h0, 0, 0, 0);  want("wd_clear", 1, c_run,    32'd0, 16'd0, 0); check_cycle();

    // Reset in the middle of a load stall leaves no bubble behind
    drive(1'b1, c_lw5, c_add, 0, 0, 0);  want("ls_hz",    1, c_hz,    32'd0, 16'd0, 0); check_cycle();
    drive(1'b0, 32'h0, c_add, 0, 0, 0);  want("ls_rst",   1, c_reset, 32'd1, 16'd0, 0); check_cycle();
    drive(1'b1, 32'h0, c_add, 0, 0, 0);  want("ls_after", 1, c_run,   32'd0, 16'd0, 0); check_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_sequencer.md
# hazard_sequencer

Registered pipeline-control sequencer for the 5-stage RV32I core. It combines load-use interlock, taken-branch squash and data-memory wait handling into a single FSM. It drives per-stage pipeline-register enables and bubble-insert flushes, replacing the free-running stall counter loop in the decode stage. It also keeps stall and flush performance counters and a sticky memory-watchdog error.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1–3
- MEM_TIMEOUT, 255, consecutive unanswered dmem cycles before the error trap; legal range 2–255
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low (the only reset; polarity and synchronicity fixed)
- if_id_ir  in  32  instruction in IF/ID (32'h0 = NOP)
- id_ex_ir  in  32  instruction in ID/EX (32'h0 = NOP)
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- dmem_req  in  1  MEM stage has an access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush  out  1 each  load 32'h0 into that register; flush overrides en
- stall_cycles  out  32  count of cycles with pc_en=0, wraps
- flush_count  out  16  count of branch squashes, wraps
- mem_timeout  out  1  sticky watchdog error

## Operation
- States: RUN, LOAD_STALL, MEM_WAIT, ERROR. Outputs are combinational from state and inputs; state and counters are registered.
- Load-use hazard (hz) requires all of the following:
  - id_ex_ir[6:0]=7'b0000011 and rd=id_ex_ir[11:7]≠0.
  - if_id_ir≠0.
  - rd matches a source register of the IF/ID instruction:
    - rs1 (if_id_ir[19:15]) counts when opcode ∉ {LUI 0110111, AUIPC 0010111, JAL 1101111}.
    - rs2 (if_id_ir[24:20]) counts when opcode ∈ {0110011, 0100011, 1100011}.
- Memory wait (mw) = dmem_req & !dmem_ready. Priority: mw > ex_branch_taken > hz.
- RUN:
  - On mw: all en=0, flushes=0, then go to MEM_WAIT.
  - On branch: all en=1, if_id_flush=1, id_ex_flush=1, flush_count+1. Any simultaneous hz is discarded.
  - On hz: pc_en=0, if_id_en=0, id_ex_flush=1, other en=1. If LOAD_STALL_CYCLES>1, load the remaining-bubble counter with LOAD_STALL_CYCLES-1 and go to LOAD_STALL.
  - Otherwise: all en=1, flushes=0.
- LOAD_STALL:
  - Outputs are the same as the hz response. ex_branch_taken and hz are ignored (EX holds a bubble).
  - Decrement the bubble counter each cycle. At 1, return to RUN.
  - On mw: freeze all stages. The bubble counter is preserved, return_state=LOAD_STALL, go to MEM_WAIT.
- MEM_WAIT:
  - All en=0, flushes=0.
  - The cycle dmem_ready=1: all en=1, flushes=0, return to return_state (RUN when entered from RUN).
  - The wait counter is cleared on entry from RUN/LOAD_STALL and increments each MEM_WAIT cycle.
- ERROR:
  - Entered when mw has held for MEM_TIMEOUT consecutive cycles, counting the entry cycle.
  - mem_timeout=1, all en=0, flushes=0. Only rst_n exits this state.
- stall_cycles increments on every cycle with pc_en=0, excluding ERROR and reset cycles.

## Timing
- Reset (rst_n=0 at clk edge) sets state=RUN, all counters=0, mem_timeout=0.
- While rst_n=0, outputs are forced: all en=0, if_id_flush=1, id_ex_flush=1. Reset mid-MEM_WAIT or mid-LOAD_STALL aborts with no residual bubble.
- Response latency is 0 cycles: hz, branch and mw act in the detection cycle.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles with pc_en=0, absent mw.
- An mw that starts in cycle t and ends with dmem_ready in cycle t+k freezes cycles t..t+k-1. Cycle t+k advances.
- mem_timeout rises in the cycle after the MEM_TIMEOUT-th consecutive mw cycle.
- Counter wrap: stall_cycles 32'hFFFFFFFF→0, flush_count 16'hFFFF→0. There is no saturation and no flag.

## Test plan
- Load-use on rs1, LOAD_STALL_CYCLES=1:
  - Stimulus: id_ex_ir=32'h0000A283 (lw x5,0(x1)), if_id_ir=32'h00728333 (add x6,x5,x7).
  - Response: same cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cycles=1.
- No-hazard cases:
  - lw x0 (id_ex_ir=32'h00002003) with rs1=x0 consumer → no stall.
  - lw x5 followed by lui x5 (if_id_ir=32'h000052B7) → no stall.
  - Either instruction word 0 → no stall.
- Branch priority: hz and ex_branch_taken=1 in the same cycle → pc_en=1, if_id_flush=1, id_ex_flush=1, flush_count=1, stall_cycles unchanged.
- Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 → all en=0 for 3 cycles, all en=1 on the 4th, stall_cycles=3.
- Watchdog and bubble resume:
  - MEM_TIMEOUT=4, dmem_ready held 0 → mem_timeout=1 in the cycle after the 4th mw cycle, enables stay 0; rst_n=0 for one cycle clears all state.
  - LOAD_STALL_CYCLES=3 with mw during the 2nd bubble → bubble count resumes after dmem_ready; total pc_en=0 cycles = 3 + wait cycles.
